// File: rtl/cronometro_pkg.sv
// rtl/cronometro_pkg.sv - shared constants, lap state encoding and BCD clamp helper
package cronometro_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [23:0] DIGIT_MAX_DEFAULT = 24'h595999;

    typedef enum logic {
        LAP_LIVE = 1'b0,
        LAP_HELD = 1'b1
    } lap_state_t;

    // Any value above the digit's maximum, including A-F, saturates to that maximum.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] digit,
                                                     input logic [DIGIT_W-1:0] max);
        return (digit > max) ? max : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one up/down BCD digit with its own modulus, load and clear
module bcd_digit_cell
    import cronometro_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clk_100hz,
    input  logic               reset,
    input  logic               step_in,
    input  logic               dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               clear,
    output logic [DIGIT_W-1:0] digit,
    output logic               at_bound,
    output logic               carry_out
);

    // Boundary is the max when counting up and zero when counting down.
    assign at_bound  = dir ? (digit == MAX) : (digit == '0);
    assign carry_out = step_in & at_bound;

    always_ff @(posedge clk_100hz or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (load) begin
            digit <= bcd_clamp(load_digit, MAX);
        end else if (step_in) begin
            if (dir) begin
                digit <= at_bound ? '0 : digit + 4'd1;
            end else begin
                digit <= at_bound ? MAX : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/contador_bcd_param.sv
// rtl/contador_bcd_param.sv - cascaded BCD stopwatch counter with wrap/saturate and lap hold
module contador_bcd_param
    import cronometro_pkg::*;
#(
    parameter int                              NUM_DIGITS = 6,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0]   DIGIT_MAX  = DIGIT_MAX_DEFAULT,
    parameter bit                              WRAP_MODE  = 1'b1
) (
    input  logic                            clk_100hz,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            clear,
    input  logic                            load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   load_value,
    input  logic                            dir,
    input  logic                            lap,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   count_bcd,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   display_bcd,
    output logic                            lap_held,
    output logic                            tc,
    output logic                            saturated
);

    logic [NUM_DIGITS:0]   chain;
    logic [NUM_DIGITS-1:0] bound;
    logic                  terminal;
    logic                  step_req;
    logic                  blocked;
    logic                  step_go;

    assign terminal = &bound;
    assign step_req = enable & ~clear & ~load;
    assign blocked  = step_req & terminal & ~WRAP_MODE;
    assign step_go  = step_req & ~blocked;
    assign chain[0] = step_go;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_cell #(
            .MAX (DIGIT_MAX[DIGIT_W*i +: DIGIT_W])
        ) u_cell (
            .clk_100hz  (clk_100hz),
            .reset      (reset),
            .step_in    (chain[i]),
            .dir        (dir),
            .load       (load),
            .load_digit (load_value[DIGIT_W*i +: DIGIT_W]),
            .clear      (clear),
            .digit      (count_bcd[DIGIT_W*i +: DIGIT_W]),
            .at_bound   (bound[i]),
            .carry_out  (chain[i+1])
        );
    end

    // A carry out of the top digit is exactly a wrap through the terminal value.
    always_ff @(posedge clk_100hz or posedge reset) begin
        if (reset) begin
            tc        <= 1'b0;
            saturated <= 1'b0;
        end else begin
            tc <= WRAP_MODE ? chain[NUM_DIGITS] : (blocked & ~saturated);
            if (clear || load || step_go) begin
                saturated <= 1'b0;
            end else if (blocked) begin
                saturated <= 1'b1;
            end
        end
    end

    lap_state_t                      lap_state;
    lap_state_t                      lap_next;
    logic                            capture;
    logic [DIGIT_W*NUM_DIGITS-1:0]   lap_reg;

    always_ff @(posedge clk_100hz or posedge reset) begin
        if (reset) begin
            lap_state <= LAP_LIVE;
            lap_reg   <= '0;
        end else begin
            lap_state <= lap_next;
            if (capture) begin
                lap_reg <= count_bcd;
            end
        end
    end

    always_comb begin
        lap_next = lap_state;
        capture  = 1'b0;
        if (clear) begin
            lap_next = LAP_LIVE;
        end else if (lap) begin
            case (lap_state)
                LAP_LIVE: begin
                    lap_next = LAP_HELD;
                    capture  = 1'b1;
                end
                LAP_HELD: lap_next = LAP_LIVE;
                default:  lap_next = LAP_LIVE;
            endcase
        end
    end

    assign lap_held    = (lap_state == LAP_HELD);
    assign display_bcd = lap_held ? lap_reg : count_bcd;

endmodule

// File: tb/tb_contador_bcd_param.sv
// tb/tb_contador_bcd_param.sv - checks wrap and saturate counters against a mixed-radix model
module tb_contador_bcd_param;

    logic        clk_100hz;
    logic        reset;
    logic        enable;
    logic        clear;
    logic        load;
    logic [23:0] load_value;
    logic        dir;
    logic        lap;

    logic [23:0] count_w, display_w, count_s, display_s;
    logic        held_w, tc_w, sat_w, held_s, tc_s, sat_s;

    int total = 0;
    int bad   = 0;

    contador_bcd_param #(.NUM_DIGITS(6), .DIGIT_MAX(24'h595999), .WRAP_MODE(1'b1)) u_wrap (
        .clk_100hz  (clk_100hz),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .dir        (dir),
        .lap        (lap),
        .count_bcd  (count_w),
        .display_bcd(display_w),
        .lap_held   (held_w),
        .tc         (tc_w),
        .saturated  (sat_w)
    );

    contador_bcd_param #(.NUM_DIGITS(6), .DIGIT_MAX(24'h595999), .WRAP_MODE(1'b0)) u_sat (
        .clk_100hz  (clk_100hz),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .dir        (dir),
        .lap        (lap),
        .count_bcd  (count_s),
        .display_bcd(display_s),
        .lap_held   (held_s),
        .tc         (tc_s),
        .saturated  (sat_s)
    );

    initial clk_100hz = 1'b0;
    always #5 clk_100hz = ~clk_100hz;

    // Model: the count is an integer in a mixed-radix system, radix of digit i = max_i + 1.
    function automatic int rad(input int i);
        logic [23:0] m;
        m = 24'h595999;
        return int'(m[4*i +: 4]) + 1;
    endfunction

    function automatic int span();
        int n;
        n = 1;
        for (int i = 0; i < 6; i++) n = n * rad(i);
        return n;
    endfunction

    function automatic int to_int(input logic [23:0] b);
        int v;
        int d;
        v = 0;
        for (int i = 5; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > rad(i) - 1) d = rad(i) - 1;
            v = v * rad(i) + d;
        end
        return v;
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % rad(i));
            x = x / rad(i);
        end
        return r;
    endfunction

    int m_val  [2] = '{0, 0};
    int m_lapv [2] = '{0, 0};
    bit m_held [2] = '{0, 0};
    bit m_tc   [2] = '{0, 0};
    bit m_sat  [2] = '{0, 0};

    // k = 0: wrap instance, k = 1: saturate instance
    task automatic model_edge(input int k);
        bit term;
        bit ntc;
        if (reset) begin
            m_val[k] = 0; m_lapv[k] = 0; m_held[k] = 0; m_tc[k] = 0; m_sat[k] = 0;
            return;
        end
        if (clear) m_held[k] = 0;
        else if (lap) begin
            if (!m_held[k]) begin
                m_lapv[k] = m_val[k];
                m_held[k] = 1;
            end else m_held[k] = 0;
        end
        ntc = 0;
        if (clear) begin
            m_val[k] = 0; m_sat[k] = 0;
        end else if (load) begin
            m_val[k] = to_int(load_value); m_sat[k] = 0;
        end else if (enable) begin
            term = dir ? (m_val[k] == span() - 1) : (m_val[k] == 0);
            if (!term) begin
                m_val[k] = dir ? m_val[k] + 1 : m_val[k] - 1;
                m_sat[k] = 0;
            end else if (k == 0) begin
                m_val[k] = dir ? 0 : span() - 1;
                ntc = 1;
            end else begin
                ntc = !m_sat[k];
                m_sat[k] = 1;
            end
        end
        m_tc[k] = ntc;
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_100hz) begin
        model_edge(0);
        model_edge(1);
        #1;
        chk("w.count",   count_w,   to_bcd(m_val[0]));
        chk("w.display", display_w, m_held[0] ? to_bcd(m_lapv[0]) : to_bcd(m_val[0]));
        chk("w.lap_held", 24'(held_w), 24'(m_held[0]));
        chk("w.tc",      24'(tc_w),  24'(m_tc[0]));
        chk("w.sat",     24'(sat_w), 24'(m_sat[0]));
        chk("s.count",   count_s,   to_bcd(m_val[1]));
        chk("s.display", display_s, m_held[1] ? to_bcd(m_lapv[1]) : to_bcd(m_val[1]));
        chk("s.lap_held", 24'(held_s), 24'(m_held[1]));
        chk("s.tc",      24'(tc_s),  24'(m_tc[1]));
        chk("s.sat",     24'(sat_s), 24'(m_sat[1]));
    end

    int tcc;

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
        load_value = '0; dir = 1'b1; lap = 1'b0;
        @(negedge clk_100hz);
        chk("rst.count", count_w, 24'h000000);
        chk("rst.flags", {held_w, tc_w, sat_s, held_s, tc_s}, 24'h0);
        reset = 1'b0;

        enable = 1'b1; dir = 1'b1;
        repeat (100) @(negedge clk_100hz);
        chk("lit.count100.w", count_w, 24'h000100);
        chk("lit.count100.s", count_s, 24'h000100);
        #1 reset = 1'b1;
        #1;
        chk("lit.async_rst", count_w | display_w | 24'({held_w, tc_w, sat_s}), 24'h0);
        @(negedge clk_100hz);
        reset = 1'b0; enable = 1'b0;
        @(negedge clk_100hz);

        load = 1'b1; load_value = 24'h595999;
        @(negedge clk_100hz);
        load = 1'b0; enable = 1'b1; dir = 1'b1;
        @(negedge clk_100hz);
        enable = 1'b0;
        chk("lit.wrap_up.count", count_w, 24'h000000);
        chk("lit.wrap_up.tc", 24'(tc_w), 24'h1);
        @(negedge clk_100hz);
        chk("lit.wrap_up.tc_drop", 24'(tc_w), 24'h0);
        load = 1'b1; load_value = 24'h000000;
        @(negedge clk_100hz);
        load = 1'b0; enable = 1'b1; dir = 1'b0;
        @(negedge clk_100hz);
        enable = 1'b0;
        chk("lit.wrap_dn.count", count_w, 24'h595999);
        chk("lit.wrap_dn.tc", 24'(tc_w), 24'h1);

        load = 1'b1; load_value = 24'h000001;
        @(negedge clk_100hz);
        load = 1'b0; enable = 1'b1; dir = 1'b0;
        tcc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_100hz);
            tcc += int'(tc_s);
        end
        chk("lit.sat.count", count_s, 24'h000000);
        chk("lit.sat.flag", 24'(sat_s), 24'h1);
        chk("lit.sat.tc_pulses", 24'(tcc), 24'h1);
        dir = 1'b1;
        @(negedge clk_100hz);
        enable = 1'b0;
        chk("lit.sat.release.count", count_s, 24'h000001);
        chk("lit.sat.release.flag", 24'(sat_s), 24'h0);

        load = 1'b1; load_value = 24'h001234;
        @(negedge clk_100hz);
        load = 1'b0; lap = 1'b1; enable = 1'b1; dir = 1'b1;
        @(negedge clk_100hz);
        lap = 1'b0;
        repeat (9) @(negedge clk_100hz);
        enable = 1'b0;
        chk("lit.lap.display", display_w, 24'h001234);
        chk("lit.lap.count", count_w, 24'h001244);
        chk("lit.lap.held", 24'(held_w), 24'h1);
        lap = 1'b1;
        @(negedge clk_100hz);
        lap = 1'b0;
        chk("lit.lap2.display", display_w, 24'h001244);
        chk("lit.lap2.held", 24'(held_w), 24'h0);

        lap = 1'b1;
        @(negedge clk_100hz);
        clear = 1'b1; load = 1'b1; lap = 1'b1; enable = 1'b1; load_value = 24'h111111;
        @(negedge clk_100hz);
        clear = 1'b0; load = 1'b0; lap = 1'b0; enable = 1'b0;
        chk("lit.prio.count", count_w, 24'h000000);
        chk("lit.prio.held", 24'(held_w), 24'h0);
        load = 1'b1; enable = 1'b1; dir = 1'b1; load_value = 24'h003456;
        @(negedge clk_100hz);
        load = 1'b0; enable = 1'b0;
        chk("lit.load_over_step", count_w, 24'h003456);

        load = 1'b1; load_value = 24'h0000AF;
        @(negedge clk_100hz);
        chk("lit.clamp_lo", count_w, 24'h000099);
        load_value = 24'h7A0000;
        @(negedge clk_100hz);
        load = 1'b0;
        chk("lit.clamp_hi", count_s, 24'h590000);
        @(negedge clk_100hz);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
